uart_rx_frame_check: RTL
========================

# uart_rx_frame_check

Parametrised frame checker for the UART receive path. It consumes one sampled bit per bit period from the data sampler. It assembles the data word LSB-first, accumulates parity serially, and checks the parity bit and one or two stop bits. At the end of each frame it emits a single-cycle result strobe and keeps sticky error status. It sits between the RX sampler/edge counter and the RX FSM/register file. It replaces the fixed 8-bit, even/odd-only parity checker.

## Interface
- DATA_W, 8, maximum data bits per frame (legal 5..9); sets P_DATA width
- CLK  in  1  receive clock
- RST  in  1  asynchronous reset, active-low
- frame_start  in  1  one-cycle pulse from the RX FSM on a validated start bit
- sample_vld  in  1  one-cycle strobe; sampled_bit is valid (at most one per bit period)
- sampled_bit  in  1  majority-voted bit value
- data_len  in  4  data bits per frame
- par_en  in  1  parity bit present
- par_mode  in  2  00 even, 01 odd, 10 mark (1), 11 space (0)
- stop2  in  1  two stop bits expected
- err_clr  in  1  clears err_status
- P_DATA  out  DATA_W  received word, right-justified, unused upper bits 0
- data_vld  out  1  one-cycle pulse; frame completed with no error
- frame_done  out  1  one-cycle pulse; frame completed, with or without error
- par_err  out  1  one-cycle pulse with frame_done; parity mismatch
- stp_err  out  1  one-cycle pulse with frame_done; a stop bit sampled 0
- err_status  out  2  sticky: [0] parity, [1] stop
- busy  out  1  high while the FSM is not in IDLE

## Operation
- Configuration latching
  - data_len, par_en, par_mode and stop2 are latched at frame_start and held for the whole frame.
  - data_len < 5 is treated as 5. data_len > DATA_W is treated as DATA_W.
- FSM states: IDLE, DATA, PAR, STOP1, STOP2, DONE.
- IDLE
  - On frame_start: go to DATA. Clear the bit index, parity accumulator, data shift register and frame error flags.
- DATA
  - On each sample_vld: write sampled_bit to bit index idx, XOR it into the accumulator, then idx++.
  - On the last bit (idx == len-1): go to PAR if par_en, else STOP1.
- PAR
  - On sample_vld, compare against the expected bit:
    - even: accumulator
    - odd: ~accumulator
    - mark: 1
    - space: 0
  - Mismatch sets the frame parity flag. Then go to STOP1.
- STOP1
  - On sample_vld: a 0 sets the frame stop flag.
  - Go to STOP2 if stop2, else DONE.
- STOP2
  - Same check as STOP1, then go to DONE.
- DONE (one cycle)
  - Load P_DATA from the shift register.
  - Pulse frame_done. Pulse par_err / stp_err per the frame flags.
  - Pulse data_vld only if both flags are clear.
  - Set the matching err_status bits. Return to IDLE.
- err_status
  - Set only by DONE; cleared only by err_clr.
  - If DONE set and err_clr occur in the same cycle, the set wins for the bits being set; other bits clear.
- P_DATA holds its value until the next DONE, including after error frames, which still load it.
- frame_start outside IDLE aborts the current frame with no DONE and restarts at DATA.
  - frame_start in the DONE cycle: DONE completes normally and the new frame starts in the same cycle.
- frame_start and sample_vld in the same cycle: frame_start wins and the sample is discarded.
- sample_vld in IDLE or DONE is ignored.

## Timing
- Reset values: P_DATA=0, data_vld=0, frame_done=0, par_err=0, stp_err=0, err_status=0, busy=0, FSM=IDLE.
- All outputs are registered.
- DONE is entered on the edge that consumes the final stop sample. Result strobes are high in the cycle immediately after the sample_vld of the last stop bit, for exactly one cycle.
- busy rises the cycle after frame_start and falls the cycle after DONE.
- Reset mid-frame: returns to IDLE immediately with no strobes. err_status clears.
- No backpressure. The consumer must capture P_DATA on data_vld or any time before the next DONE.

## Test plan
- 8N1, 0xA5 sent LSB-first (1,0,1,0,0,1,0,1), stop=1: P_DATA=0xA5; data_vld, frame_done high for exactly one cycle after the stop sample; no errors; busy low the next cycle.
- 8E1, 0xA5, parity bit 1 (expected 0): par_err=1, frame_done=1, data_vld=0, err_status=01, P_DATA=0xA5. Then err_clr gives err_status=00.
- 7O2, 0x3C (expected parity 1), stop bits 1,0: stp_err=1, par_err=0, err_status=10. Repeat with stop2=0 and only stop=1: clean frame.
- DATA_W=9, data_len=9, mark parity, data 0x1FF, parity 1: clean frame, P_DATA=0x1FF. Repeat with data_len=3: treated as 5, P_DATA=0x1F.
- frame_start after 4 data bits, then a full 8N1 frame of 0x5A: no strobe for the aborted frame, single data_vld with P_DATA=0x5A. Also frame_start coincident with sample_vld: the sample is discarded.
- RST asserted during PAR: all outputs 0, FSM idle. A subsequent 8N1 frame of 0x00 completes cleanly.

Source files
------------

// File: rtl/uart_rx_frame_check_if.sv
// Signal bundle between the RX sampler/FSM (master) and the frame checker (slave).
interface uart_rx_frame_check_if #(
  parameter int DATA_W = 8
);
  logic              frame_start;
  logic              sample_vld;
  logic              sampled_bit;
  logic [3:0]        data_len;
  logic              par_en;
  logic [1:0]        par_mode;
  logic              stop2;
  logic              err_clr;
  logic [DATA_W-1:0] P_DATA;
  logic              data_vld;
  logic              frame_done;
  logic              par_err;
  logic              stp_err;
  logic [1:0]        err_status;
  logic              busy;

  modport master (
    output frame_start, sample_vld, sampled_bit, data_len, par_en, par_mode, stop2, err_clr,
    input  P_DATA, data_vld, frame_done, par_err, stp_err, err_status, busy
  );

  modport slave (
    input  frame_start, sample_vld, sampled_bit, data_len, par_en, par_mode, stop2, err_clr,
    output P_DATA, data_vld, frame_done, par_err, stp_err, err_status, busy
  );
endinterface

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: LSB-first word assembly, serial parity, 1/2 stop-bit check,
// per-frame result strobes and sticky error status.
module uart_rx_frame_check #(
  parameter int DATA_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_rx_frame_check_if.slave  rx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_PAR   = 3'd2;
  localparam logic [2:0] S_STOP1 = 3'd3;
  localparam logic [2:0] S_STOP2 = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    if (l < 4'd5)              return 4'd5;
    else if (l > 4'(DATA_W))   return 4'(DATA_W);
    else                       return l;
  endfunction

  function automatic logic par_expect(input logic [1:0] mode, input logic acc_v);
    case (mode)
      2'b00:   return acc_v;
      2'b01:   return ~acc_v;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic [2:0]        state, nxt;
  logic [3:0]        idx;
  logic              fpar, fstp;
  logic              fin, stp_now;
  logic [DATA_W-1:0] shreg;
  logic              acc;
  logic [3:0]        len_q;
  logic              par_en_q, stop2_q;
  logic [1:0]        par_mode_q;

  logic [DATA_W-1:0] p_data_r;
  logic              data_vld_r, frame_done_r, par_err_r, stp_err_r, busy_r;
  logic [1:0]        err_status_r;

  // frame_start overrides every state, so an aborted frame never reaches DONE
  always_comb begin
    nxt = state;
    fin = 1'b0;
    if (rx.frame_start) begin
      nxt = S_DATA;
    end else begin
      case (state)
        S_DATA:  if (rx.sample_vld && idx == len_q - 4'd1) nxt = par_en_q ? S_PAR : S_STOP1;
        S_PAR:   if (rx.sample_vld) nxt = S_STOP1;
        S_STOP1: if (rx.sample_vld) begin
                   nxt = stop2_q ? S_STOP2 : S_DONE;
                   fin = ~stop2_q;
                 end
        S_STOP2: if (rx.sample_vld) begin
                   nxt = S_DONE;
                   fin = 1'b1;
                 end
        S_DONE:  nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  assign stp_now = fstp | ~rx.sampled_bit;

  // Datapath registers: cleared/loaded by frame_start, no reset needed
  always_ff @(posedge CLK) begin
    if (rx.frame_start) begin
      shreg      <= '0;
      acc        <= 1'b0;
      len_q      <= clamp_len(rx.data_len);
      par_en_q   <= rx.par_en;
      par_mode_q <= rx.par_mode;
      stop2_q    <= rx.stop2;
    end else if (rx.sample_vld && state == S_DATA) begin
      shreg <= shreg | (DATA_W'(rx.sampled_bit) << idx);
      acc   <= acc ^ rx.sampled_bit;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= S_IDLE;
      idx          <= 4'd0;
      fpar         <= 1'b0;
      fstp         <= 1'b0;
      p_data_r     <= '0;
      data_vld_r   <= 1'b0;
      frame_done_r <= 1'b0;
      par_err_r    <= 1'b0;
      stp_err_r    <= 1'b0;
      err_status_r <= 2'b00;
      busy_r       <= 1'b0;
    end else begin
      state        <= nxt;
      busy_r       <= (nxt != S_IDLE);
      data_vld_r   <= 1'b0;
      frame_done_r <= 1'b0;
      par_err_r    <= 1'b0;
      stp_err_r    <= 1'b0;
      if (rx.frame_start) begin
        idx  <= 4'd0;
        fpar <= 1'b0;
        fstp <= 1'b0;
      end else if (rx.sample_vld) begin
        case (state)
          S_DATA:          idx <= idx + 4'd1;
          S_PAR:           if (rx.sampled_bit != par_expect(par_mode_q, acc)) fpar <= 1'b1;
          S_STOP1, S_STOP2: if (!rx.sampled_bit) fstp <= 1'b1;
          default: ;
        endcase
      end
      if (fin) begin
        p_data_r     <= shreg;
        frame_done_r <= 1'b1;
        par_err_r    <= fpar;
        stp_err_r    <= stp_now;
        data_vld_r   <= ~fpar & ~stp_now;
      end
      // a simultaneous set beats err_clr only for the bits being set
      err_status_r <= (err_status_r & ~{2{rx.err_clr}}) | (fin ? {stp_now, fpar} : 2'b00);
    end
  end

  assign rx.P_DATA     = p_data_r;
  assign rx.data_vld   = data_vld_r;
  assign rx.frame_done = frame_done_r;
  assign rx.par_err    = par_err_r;
  assign rx.stp_err    = stp_err_r;
  assign rx.err_status = err_status_r;
  assign rx.busy       = busy_r;

endmodule
